// File: rtl/common.sv
// Shared SAT-solver types: literals, propagation status codes, decision stack entries
// and the DPLL sequencer state encoding.
package common;

    // Literal index width; covers up to 16 variables.
    localparam int unsigned LIT_NUM_W = 4;

    typedef struct packed {
        logic [LIT_NUM_W-1:0] num;
        logic                 val;
    } lit;

    localparam lit zero_lit = '{num: '0, val: 1'b0};

    // 2'b11 is reserved and handled as a conflict by consumers.
    typedef enum logic [1:0] {
        PROP_UNDET    = 2'b00,
        PROP_SAT      = 2'b01,
        PROP_CONFLICT = 2'b10
    } prop_status_t;

    typedef struct packed {
        lit   l;
        logic flipped;
    } dec_entry;

    typedef enum logic [2:0] {
        StIdle,
        StPropReq,
        StPropWait,
        StDecReq,
        StDecWait,
        StBacktrack,
        StDone
    } ctrl_state_t;

endpackage

// File: rtl/decision_stack.sv
// LIFO of decision entries with push, pop and in-place flip of the top entry.
// At most one operation per cycle; push wins over pop, pop over flip.
module decision_stack
    import common::*;
#(
    parameter int unsigned MAX_DEPTH = 16,
    parameter int unsigned DEPTH_W   = $clog2(MAX_DEPTH + 1)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               clear_i,
    input  logic               push_i,
    input  dec_entry           push_entry_i,
    input  logic               pop_i,
    input  logic               flip_top_i,
    output dec_entry           top_o,
    output logic [DEPTH_W-1:0] count_o
);

    localparam int unsigned IdxW = (MAX_DEPTH > 1) ? $clog2(MAX_DEPTH) : 1;
    localparam logic [DEPTH_W-1:0] FullDepth = DEPTH_W'(MAX_DEPTH);

    dec_entry           entries_q [MAX_DEPTH];
    logic [DEPTH_W-1:0] count_q;
    logic [IdxW-1:0]    top_idx;
    logic [IdxW-1:0]    push_idx;

    assign top_idx  = IdxW'(count_q - 1'b1);
    assign push_idx = IdxW'(count_q);
    assign top_o    = (count_q != '0) ? entries_q[top_idx] : '0;
    assign count_o  = count_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
            for (int i = 0; i < int'(MAX_DEPTH); i++) begin
                entries_q[i] <= '0;
            end
        end else if (clear_i) begin
            count_q <= '0;
        end else if (push_i && (count_q != FullDepth)) begin
            entries_q[push_idx] <= push_entry_i;
            count_q             <= count_q + 1'b1;
        end else if (pop_i && (count_q != '0)) begin
            count_q <= count_q - 1'b1;
        end else if (flip_top_i && (count_q != '0)) begin
            entries_q[top_idx].l.val   <= ~entries_q[top_idx].l.val;
            entries_q[top_idx].flipped <= 1'b1;
        end
    end

endmodule

// File: rtl/dpll_controller.sv
// DPLL sequencer: drives decision and propagation units, owns assignments and chronological
// backtracking. Define DPLL_CONTROLLER_STATS_EN to add decision/conflict counters.
module dpll_controller
    import common::*;
#(
    parameter int unsigned NUM_VARS  = 16,
    parameter int unsigned MAX_DEPTH = 16,
    parameter int unsigned DEPTH_W   = $clog2(MAX_DEPTH + 1)
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                start,
    output logic                busy,
    output logic                done,
    output logic                result_sat,
    output logic                result_unsat,
    output logic                error,
    output logic                dec_find,
    input  logic                dec_ended,
    input  lit                  dec_lit,
    output logic                prop_start,
    input  logic                prop_done,
    input  logic [1:0]          prop_status,
    output logic [NUM_VARS-1:0] assign_set,
    output logic [NUM_VARS-1:0] assign_val,
    output logic [DEPTH_W-1:0]  depth
`ifdef DPLL_CONTROLLER_STATS_EN
    ,
    output logic [31:0]         stat_decisions,
    output logic [31:0]         stat_conflicts
`endif
);

    localparam logic [DEPTH_W-1:0] FullDepth = DEPTH_W'(MAX_DEPTH);

    ctrl_state_t         state_q, state_d;
    logic [NUM_VARS-1:0] assign_set_q, assign_set_d;
    logic [NUM_VARS-1:0] assign_val_q, assign_val_d;
    logic                sat_q, sat_d, unsat_q, unsat_d, err_q, err_d;

    logic                stk_clear, stk_push, stk_pop, stk_flip;
    dec_entry            stk_top, push_entry;
    logic [DEPTH_W-1:0]  stk_count;

    logic                start_accept, dec_accept, dec_illegal, conflict_seen, lit_in_range;

    assign push_entry    = '{l: dec_lit, flipped: 1'b0};
    assign lit_in_range  = 32'(dec_lit.num) < NUM_VARS;
    assign dec_illegal   = (stk_count == FullDepth) || !lit_in_range || assign_set_q[dec_lit.num];
    assign start_accept  = start && ((state_q == StIdle) || (state_q == StDone));
    assign dec_accept    = (state_q == StDecWait) && dec_ended && !dec_illegal;
    assign conflict_seen = (state_q == StPropWait) && prop_done &&
                           (prop_status != PROP_SAT) && (prop_status != PROP_UNDET);

    decision_stack #(
        .MAX_DEPTH (MAX_DEPTH),
        .DEPTH_W   (DEPTH_W)
    ) u_stack (
        .clock        (clock),
        .reset        (reset),
        .clear_i      (stk_clear),
        .push_i       (stk_push),
        .push_entry_i (push_entry),
        .pop_i        (stk_pop),
        .flip_top_i   (stk_flip),
        .top_o        (stk_top),
        .count_o      (stk_count)
    );

    always_comb begin
        state_d      = state_q;
        assign_set_d = assign_set_q;
        assign_val_d = assign_val_q;
        sat_d        = sat_q;
        unsat_d      = unsat_q;
        err_d        = err_q;
        stk_clear    = 1'b0;
        stk_push     = 1'b0;
        stk_pop      = 1'b0;
        stk_flip     = 1'b0;

        unique case (state_q)
            StIdle, StDone: begin
                if (start_accept) begin
                    assign_set_d = '0;
                    assign_val_d = '0;
                    sat_d        = 1'b0;
                    unsat_d      = 1'b0;
                    err_d        = 1'b0;
                    stk_clear    = 1'b1;
                    state_d      = StPropReq;
                end
            end
            StPropReq: state_d = StPropWait;
            StPropWait: begin
                if (prop_done) begin
                    if (prop_status == PROP_SAT) begin
                        sat_d   = 1'b1;
                        state_d = StDone;
                    end else if (prop_status == PROP_UNDET) begin
                        state_d = StDecReq;
                    end else begin
                        state_d = StBacktrack;
                    end
                end
            end
            StDecReq: state_d = StDecWait;
            StDecWait: begin
                if (dec_ended) begin
                    if (dec_illegal) begin
                        err_d   = 1'b1;
                        state_d = StDone;
                    end else begin
                        stk_push                   = 1'b1;
                        assign_set_d[dec_lit.num] = 1'b1;
                        assign_val_d[dec_lit.num] = dec_lit.val;
                        state_d                    = StPropReq;
                    end
                end
            end
            StBacktrack: begin
                // Pop exhausted (already flipped) decisions one per cycle, then try the other branch.
                if (stk_count == '0) begin
                    unsat_d = 1'b1;
                    state_d = StDone;
                end else if (stk_top.flipped) begin
                    assign_set_d[stk_top.l.num] = 1'b0;
                    stk_pop                      = 1'b1;
                end else begin
                    assign_val_d[stk_top.l.num] = ~assign_val_q[stk_top.l.num];
                    stk_flip                     = 1'b1;
                    state_d                      = StPropReq;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= StIdle;
            assign_set_q <= '0;
            assign_val_q <= '0;
            sat_q        <= 1'b0;
            unsat_q      <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            assign_set_q <= assign_set_d;
            assign_val_q <= assign_val_d;
            sat_q        <= sat_d;
            unsat_q      <= unsat_d;
            err_q        <= err_d;
        end
    end

    assign busy         = (state_q != StIdle) && (state_q != StDone);
    assign done         = (state_q == StDone);
    assign prop_start   = (state_q == StPropReq);
    assign dec_find     = (state_q == StDecReq);
    assign result_sat   = sat_q;
    assign result_unsat = unsat_q;
    assign error        = err_q;
    assign assign_set   = assign_set_q;
    assign assign_val   = assign_val_q;
    assign depth        = stk_count;

`ifdef DPLL_CONTROLLER_STATS_EN
    logic [31:0] stat_dec_q, stat_conf_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stat_dec_q  <= '0;
            stat_conf_q <= '0;
        end else if (start_accept) begin
            stat_dec_q  <= '0;
            stat_conf_q <= '0;
        end else begin
            if (dec_accept && (stat_dec_q != '1)) begin
                stat_dec_q <= stat_dec_q + 32'd1;
            end
            if (conflict_seen && (stat_conf_q != '1)) begin
                stat_conf_q <= stat_conf_q + 32'd1;
            end
        end
    end

    assign stat_decisions = stat_dec_q;
    assign stat_conflicts = stat_conf_q;
`else
    logic unused_stats;
    assign unused_stats = dec_accept ^ conflict_seen;
`endif

endmodule
